mem_rdata_checker: RTL and testbench

Read-return end of the memory controller's BIST path. It watches the registered MEM_* command stream that the controller drives into the 64 SRAM banks and tracks every read through the bank latency. It selects the returning byte from the bank data bus and hands it back to BIST as BIST_ODATA, compares that byte against the expected pattern, and logs failing 16-bit addresses into a small FIFO that the repair logic drains.

---
 rtl/mem_rdata_checker_pkg.sv | 39 +++
 rtl/mem_rdata_checker_fail_log.sv | 137 +++++++++++++
 rtl/mem_rdata_checker.sv | 191 +++++++++++++++++++
 tb/tb_mem_rdata_checker.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rdata_checker_pkg.sv
// ---------------------------------------------------------------------------
// mem_rdata_checker_pkg
//
// Shared definitions for the BIST read-return checker:
//   - geometry of the SRAM bank array and of the fail-log entries
//   - rd_tag_t: everything about a read that must travel alongside it
//     through the bank latency
//   - csb_ok(): decides whether a read's chip selects are consistent with
//     the bank it claims to read from
// ---------------------------------------------------------------------------
package mem_rdata_checker_pkg;

    localparam int N_BANK  = 64;
    localparam int BANK_W  = 6;
    localparam int WADDR_W = 10;
    localparam int FADDR_W = 16;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;

    typedef struct packed {
        logic [BANK_W-1:0]  bank;
        logic [WADDR_W-1:0] addr;
        logic               cmp_en;
        logic [DATA_W-1:0]  exp_data;
        logic               csb_ok;
    } rd_tag_t;

    // Exactly one chip select low, and it is the selected bank. Comparing
    // the inverted CSB vector against a one-hot of the select covers both
    // the "zero low" and "several low" cases in one equality.
    function automatic logic csb_ok(input logic [N_BANK-1:0] csb,
                                    input logic [BANK_W-1:0] sel);
        logic [N_BANK-1:0] w_onehot;
        w_onehot      = '0;
        w_onehot[sel] = 1'b1;
        return (~csb == w_onehot);
    endfunction

endpackage

// File: rtl/mem_rdata_checker_fail_log.sv
// ---------------------------------------------------------------------------
// mem_fail_log
//
// LOG_DEPTH-entry FIFO of failing {bank, addr} words.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push           mismatch to record this cycle
//   i_push_data      {bank, addr} of the mismatch
//   i_pop            consumer ready; pops only when the log is not empty
//   i_clear          empties the log and clears the overflow flag; it
//                    takes priority over a same-cycle push or pop
//   o_empty          log holds no entries
//   o_overflow       sticky: a push was dropped because the log was full
//   o_head           registered head entry; holds its last value when empty
//
// Build option MEM_RDATA_CHECKER_DEDUP_EN: every valid entry is compared in
// parallel against the incoming word, and a match suppresses the push (so a
// duplicate can never be dropped and can never raise the overflow flag).
// ---------------------------------------------------------------------------
module mem_fail_log
    import mem_rdata_checker_pkg::*;
#(
    parameter int LOG_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [FADDR_W-1:0] i_push_data,
    input  logic               i_pop,
    input  logic               i_clear,
    output logic               o_empty,
    output logic               o_overflow,
    output logic [FADDR_W-1:0] o_head
);

    localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int CNT_LW = PTR_W + 1;
    localparam logic [CNT_LW-1:0] DEPTH_C = CNT_LW'(LOG_DEPTH);

    logic [FADDR_W-1:0] r_mem [LOG_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_LW-1:0]  r_count;
    logic               r_overflow;
    logic [FADDR_W-1:0] r_head;

    logic               w_full;
    logic               w_empty;
    logic               w_dup;
    logic               w_push_req;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_drop;
    logic [PTR_W-1:0]   w_rptr_next;
    logic [CNT_LW-1:0]  w_count_next;
    logic [FADDR_W-1:0] w_head_next;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

`ifdef MEM_RDATA_CHECKER_DEDUP_EN
    // An entry is live when its distance from the read pointer is below the
    // occupancy; pointer subtraction wraps because the depth is a power of 2.
    logic [LOG_DEPTH-1:0] w_hit_vec;
    genvar gi;
    generate
        for (gi = 0; gi < LOG_DEPTH; gi++) begin : g_dedup
            logic [PTR_W-1:0] w_ofs;
            assign w_ofs         = PTR_W'(gi) - r_rptr;
            assign w_hit_vec[gi] = ({1'b0, w_ofs} < r_count) &&
                                   (r_mem[gi] == i_push_data);
        end
    endgenerate
    assign w_dup = |w_hit_vec;
`else
    assign w_dup = 1'b0;
`endif

    assign w_push_req = i_push & ~w_dup;
    assign w_pop      = i_pop & ~w_empty;
    // A full log still accepts the push when the head leaves this cycle.
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    assign w_rptr_next  = r_rptr + PTR_W'(w_pop);
    assign w_count_next = r_count + CNT_LW'(w_push_ok) - CNT_LW'(w_pop);

    // The new head is the word being written only when it lands on the slot
    // the read pointer moves to (log empty, or one entry being replaced).
    always_comb begin
        w_head_next = r_mem[w_rptr_next];
        if (w_push_ok && (r_wptr == w_rptr_next)) begin
            w_head_next = i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_head     <= '0;
        end else if (i_clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_count_next != '0) begin
                r_head <= w_head_next;
            end
        end
    end

    // Storage carries no reset: entries are only ever read once the
    // occupancy count says they were written.
    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_clear) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;
    assign o_head     = r_head;

endmodule

// File: rtl/mem_rdata_checker.sv
// ---------------------------------------------------------------------------
// mem_rdata_checker
//
// Read-return end of the BIST path. Snoops the registered MEM_* command
// stream, carries each read's tag through the bank latency, returns the
// selected byte to BIST, compares it with the expected byte, and logs
// failing {bank, addr} words for the repair logic.
//
// Parameters:
//   RD_LAT     bank read latency, command to valid bus data (1..3)
//   LOG_DEPTH  fail-log entries (power of two, 2..16)
//
// Ports:
//   CLK, RSTN            clock, asynchronous active-low reset
//   MEM_ADDR/CE/WEB/CSB  command stream (read = CE & WEB)
//   MEM_ODATA_SELECT     bank index of the current read
//   MEM_ODATA_BUS        bank read data, bank k at [8k+7:8k]
//   CMP_EN, EXP_DATA     compare qualifier / expected byte, with the command
//   LOG_CLR              clears log, FAIL_COUNT, FAIL_OVERFLOW, CSB_ERR
//   BIST_ODATA(_VALID)   returned byte and its one-cycle valid pulse
//   FAIL_VALID/ADDR      fail-log head, popped by FAIL_READY
//   FAIL_COUNT           saturating mismatch count since last clear
//   FAIL_OVERFLOW        sticky: a mismatch was dropped on a full log
//   CSB_ERR              sticky: a read had inconsistent chip selects
//
// Build option MEM_RDATA_CHECKER_DEDUP_EN: repeated failing addresses
// already in the log are counted but not logged again.
//
// Pipeline (read command in cycle T):
//   T+1 .. T+RD_LAT  tag delay line; bus byte sampled in T+RD_LAT
//   T+RD_LAT+1       BIST_ODATA valid, compare evaluated, push at its end
//   T+RD_LAT+2       FAIL_VALID / FAIL_COUNT reflect the result
// ---------------------------------------------------------------------------
module mem_rdata_checker
    import mem_rdata_checker_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int LOG_DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic [WADDR_W-1:0]       MEM_ADDR,
    input  logic                     MEM_CE,
    input  logic                     MEM_WEB,
    input  logic [N_BANK-1:0]        MEM_CSB,
    input  logic [BANK_W-1:0]        MEM_ODATA_SELECT,
    input  logic [N_BANK*DATA_W-1:0] MEM_ODATA_BUS,
    input  logic                     CMP_EN,
    input  logic [DATA_W-1:0]        EXP_DATA,
    input  logic                     LOG_CLR,
    output logic [DATA_W-1:0]        BIST_ODATA,
    output logic                     BIST_ODATA_VALID,
    output logic                     FAIL_VALID,
    output logic [FADDR_W-1:0]       FAIL_ADDR,
    input  logic                     FAIL_READY,
    output logic [CNT_W-1:0]         FAIL_COUNT,
    output logic                     FAIL_OVERFLOW,
    output logic                     CSB_ERR
);

    // ---------------- command capture ----------------
    logic    w_cmd_rd;
    rd_tag_t w_cmd_tag;

    assign w_cmd_rd = MEM_CE & MEM_WEB;

    always_comb begin
        w_cmd_tag          = '0;
        w_cmd_tag.bank     = MEM_ODATA_SELECT;
        w_cmd_tag.addr     = MEM_ADDR;
        w_cmd_tag.cmp_en   = CMP_EN;
        w_cmd_tag.exp_data = EXP_DATA;
        w_cmd_tag.csb_ok   = csb_ok(MEM_CSB, MEM_ODATA_SELECT);
    end

    // ---------------- tag delay line, RD_LAT deep ----------------
    logic [RD_LAT-1:0] r_pipe_vld;
    rd_tag_t           r_pipe_tag [RD_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge CLK or negedge RSTN) begin
                    if (!RSTN) begin
                        r_pipe_vld[0] <= 1'b0;
                        r_pipe_tag[0] <= '0;
                    end else begin
                        r_pipe_vld[0] <= w_cmd_rd;
                        if (w_cmd_rd) begin
                            r_pipe_tag[0] <= w_cmd_tag;
                        end
                    end
                end
            end else begin : g_body
                always_ff @(posedge CLK or negedge RSTN) begin
                    if (!RSTN) begin
                        r_pipe_vld[gi] <= 1'b0;
                        r_pipe_tag[gi] <= '0;
                    end else begin
                        r_pipe_vld[gi] <= r_pipe_vld[gi-1];
                        r_pipe_tag[gi] <= r_pipe_tag[gi-1];
                    end
                end
            end
        end
    endgenerate

    // ---------------- data stage ----------------
    logic              w_dat_vld;
    rd_tag_t           w_dat_tag;
    logic [DATA_W-1:0] w_bus_byte;

    assign w_dat_vld  = r_pipe_vld[RD_LAT-1];
    assign w_dat_tag  = r_pipe_tag[RD_LAT-1];
    assign w_bus_byte = MEM_ODATA_BUS[{w_dat_tag.bank, 3'b000} +: DATA_W];

    logic [DATA_W-1:0] r_bist_odata;
    logic              r_odata_vld;
    rd_tag_t           r_cmp_tag;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_bist_odata <= '0;
            r_odata_vld  <= 1'b0;
            r_cmp_tag    <= '0;
        end else begin
            r_odata_vld <= w_dat_vld;
            if (w_dat_vld) begin
                r_bist_odata <= w_bus_byte;
                r_cmp_tag    <= w_dat_tag;
            end
        end
    end

    // ---------------- compare stage ----------------
    // r_odata_vld doubles as the compare-stage valid: the tag registered
    // next to BIST_ODATA belongs to exactly that returned byte.
    logic               w_mismatch;
    logic               w_csb_bad;
    logic [FADDR_W-1:0] w_fail_word;

    assign w_mismatch  = r_odata_vld & r_cmp_tag.cmp_en & r_cmp_tag.csb_ok &
                         (r_bist_odata != r_cmp_tag.exp_data);
    assign w_csb_bad   = r_odata_vld & ~r_cmp_tag.csb_ok;
    assign w_fail_word = {r_cmp_tag.bank, r_cmp_tag.addr};

    logic [CNT_W-1:0] r_fail_count;
    logic             r_csb_err;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_fail_count <= '0;
            r_csb_err    <= 1'b0;
        end else if (LOG_CLR) begin
            r_fail_count <= '0;
            r_csb_err    <= 1'b0;
        end else begin
            if (w_mismatch && (r_fail_count != '1)) begin
                r_fail_count <= r_fail_count + CNT_W'(1);
            end
            if (w_csb_bad) begin
                r_csb_err <= 1'b1;
            end
        end
    end

    // ---------------- fail log ----------------
    logic w_log_empty;

    mem_fail_log #(
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fail_log (
        .i_clk       (CLK),
        .i_rst_n     (RSTN),
        .i_push      (w_mismatch),
        .i_push_data (w_fail_word),
        .i_pop       (FAIL_READY),
        .i_clear     (LOG_CLR),
        .o_empty     (w_log_empty),
        .o_overflow  (FAIL_OVERFLOW),
        .o_head      (FAIL_ADDR)
    );

    assign BIST_ODATA       = r_bist_odata;
    assign BIST_ODATA_VALID = r_odata_vld;
    assign FAIL_VALID       = ~w_log_empty;
    assign FAIL_COUNT       = r_fail_count;
    assign CSB_ERR          = r_csb_err;

endmodule

// File: tb/tb_mem_rdata_checker.sv
module tb_mem_rdata_checker;
    import mem_rdata_checker_pkg::*;

    localparam int RD_LAT    = 1;
    localparam int LOG_DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic [9:0]   MEM_ADDR;
    logic         MEM_CE;
    logic         MEM_WEB;
    logic [63:0]  MEM_CSB;
    logic [5:0]   MEM_ODATA_SELECT;
    logic [511:0] MEM_ODATA_BUS;
    logic         CMP_EN;
    logic [7:0]   EXP_DATA;
    logic         LOG_CLR;
    logic [7:0]   BIST_ODATA;
    logic         BIST_ODATA_VALID;
    logic         FAIL_VALID;
    logic [15:0]  FAIL_ADDR;
    logic         FAIL_READY;
    logic [7:0]   FAIL_COUNT;
    logic         FAIL_OVERFLOW;
    logic         CSB_ERR;

    always #5 CLK = ~CLK;

    mem_rdata_checker #(
        .RD_LAT    (RD_LAT),
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .CLK              (CLK),
        .RSTN             (RSTN),
        .MEM_ADDR         (MEM_ADDR),
        .MEM_CE           (MEM_CE),
        .MEM_WEB          (MEM_WEB),
        .MEM_CSB          (MEM_CSB),
        .MEM_ODATA_SELECT (MEM_ODATA_SELECT),
        .MEM_ODATA_BUS    (MEM_ODATA_BUS),
        .CMP_EN           (CMP_EN),
        .EXP_DATA         (EXP_DATA),
        .LOG_CLR          (LOG_CLR),
        .BIST_ODATA       (BIST_ODATA),
        .BIST_ODATA_VALID (BIST_ODATA_VALID),
        .FAIL_VALID       (FAIL_VALID),
        .FAIL_ADDR        (FAIL_ADDR),
        .FAIL_READY       (FAIL_READY),
        .FAIL_COUNT       (FAIL_COUNT),
        .FAIL_OVERFLOW    (FAIL_OVERFLOW),
        .CSB_ERR          (CSB_ERR)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboards: returned bytes in read order, logged words in FIFO order.
    logic [7:0]  bq [$];
    logic [15:0] fq [$];
    logic [7:0]  mon_b;
    logic [15:0] mon_f;

    // Monitor: every returned byte and every popped log head.
    always @(negedge CLK) begin
        if (RSTN === 1'b1 && BIST_ODATA_VALID === 1'b1) begin
            checks++;
            if (bq.size() == 0) begin
                errors++;
                $display("FAIL bist_unexpected got %02h required no valid", BIST_ODATA);
            end else begin
                mon_b = bq.pop_front();
                if (BIST_ODATA !== mon_b) begin
                    errors++;
                    $display("FAIL bist_data got %02h required %02h", BIST_ODATA, mon_b);
                end else
                    $display("read return %02h", BIST_ODATA);
            end
        end
        if (RSTN === 1'b1 && FAIL_VALID === 1'b1 && FAIL_READY === 1'b1) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL log_unexpected got %04h required empty log", FAIL_ADDR);
            end else begin
                mon_f = fq.pop_front();
                if (FAIL_ADDR !== mon_f) begin
                    errors++;
                    $display("FAIL log_pop got %04h required %04h", FAIL_ADDR, mon_f);
                end else
                    $display("log pop %04h", FAIL_ADDR);
            end
        end
    end

    function automatic logic [63:0] csb_of(input int b);
        logic [63:0] v;
        v    = '1;
        v[b] = 1'b0;
        return v;
    endfunction

    function automatic logic [15:0] fw(input int b, input int a);
        return {6'(b), 10'(a)};
    endfunction

    task automatic set_bus();
        for (int k = 0; k < 64; k++) MEM_ODATA_BUS[8*k +: 8] = 8'(k * 7 + 17);
    endtask

    task automatic idle();
        @(posedge CLK); #1;
        MEM_CE = 1'b0; MEM_WEB = 1'b0; CMP_EN = 1'b0;
        MEM_CSB = '1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) idle();
    endtask

    // One read per call; the expected returned byte is what the bench drives
    // on the bus for that bank (the bus is held stable while reads fly).
    task automatic rd(input int b, input int a, input logic cmp,
                      input logic [7:0] e, input logic [63:0] csb);
        @(posedge CLK); #1;
        MEM_CE = 1'b1; MEM_WEB = 1'b1; MEM_ADDR = 10'(a);
        MEM_ODATA_SELECT = 6'(b); MEM_CSB = csb; CMP_EN = cmp; EXP_DATA = e;
        bq.push_back(MEM_ODATA_BUS[8*b +: 8]);
    endtask

    // Read that must mismatch: expected is the inverse of the bus byte.
    task automatic rd_bad(input int b, input int a);
        rd(b, a, 1'b1, ~MEM_ODATA_BUS[8*b +: 8], csb_of(b));
    endtask

    task automatic clr();
        idle(); LOG_CLR = 1'b1;
        idle(); LOG_CLR = 1'b0;
    endtask

    task automatic drain(input int n);
        idle(); FAIL_READY = 1'b1;
        idle_n(n);
        FAIL_READY = 1'b0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; MEM_CE = 0; MEM_WEB = 0; MEM_CSB = '1; MEM_ADDR = 0;
        MEM_ODATA_SELECT = 0; CMP_EN = 0; EXP_DATA = 0; LOG_CLR = 0; FAIL_READY = 0;
        set_bus();
        #12;
        checks += 3;
        if (BIST_ODATA !== 8'h00 || BIST_ODATA_VALID !== 1'b0) begin
            errors++; $display("FAIL rst_bist got %02h/%b required 00/0", BIST_ODATA, BIST_ODATA_VALID);
        end
        if (FAIL_VALID !== 1'b0 || FAIL_ADDR !== 16'h0 || FAIL_COUNT !== 8'h0) begin
            errors++; $display("FAIL rst_log got %b/%04h/%02h required 0/0000/00", FAIL_VALID, FAIL_ADDR, FAIL_COUNT);
        end
        if (FAIL_OVERFLOW !== 1'b0 || CSB_ERR !== 1'b0) begin
            errors++; $display("FAIL rst_flags got %b/%b required 0/0", FAIL_OVERFLOW, CSB_ERR);
        end
        $display("reset state checked");
        @(negedge CLK); RSTN = 1'b1;
        idle_n(2);
    endtask

    task automatic test_match();
        MEM_ODATA_BUS[8*5 +: 8] = 8'hA5;
        rd(5, 10'h3A1, 1'b1, 8'hA5, csb_of(5));
        idle_n(2);
        checks++;
        if (BIST_ODATA !== 8'hA5 || BIST_ODATA_VALID !== 1'b1) begin
            errors++; $display("FAIL match_bist got %02h/%b required a5/1", BIST_ODATA, BIST_ODATA_VALID);
        end
        idle();
        checks++;
        if (FAIL_VALID !== 1'b0 || FAIL_COUNT !== 8'd0) begin
            errors++; $display("FAIL match_nolog got %b/%0d required 0/0", FAIL_VALID, FAIL_COUNT);
        end
        checks++;
        if (BIST_ODATA !== 8'hA5 || BIST_ODATA_VALID !== 1'b0) begin
            errors++; $display("FAIL match_hold got %02h/%b required a5/0", BIST_ODATA, BIST_ODATA_VALID);
        end
    endtask

    task automatic test_mismatch();
        MEM_ODATA_BUS[8*5 +: 8] = 8'h5A;
        rd(5, 10'h3A1, 1'b1, 8'hA5, csb_of(5));
        fq.push_back(16'h17A1);
        idle_n(2);
        checks++;
        if (FAIL_VALID !== 1'b0 || BIST_ODATA !== 8'h5A) begin
            errors++; $display("FAIL mis_early got %b/%02h required 0/5a", FAIL_VALID, BIST_ODATA);
        end
        idle();
        checks++;
        if (FAIL_VALID !== 1'b1 || FAIL_ADDR !== 16'h17A1 || FAIL_COUNT !== 8'd1) begin
            errors++; $display("FAIL mis_log got %b/%04h/%0d required 1/17a1/1", FAIL_VALID, FAIL_ADDR, FAIL_COUNT);
        end
        drain(1);
        checks++;
        if (FAIL_VALID !== 1'b0 || FAIL_ADDR !== 16'h17A1 || fq.size() != 0) begin
            errors++; $display("FAIL mis_drain got %b/%04h/%0d required 0/17a1/0", FAIL_VALID, FAIL_ADDR, fq.size());
        end
    endtask

    task automatic test_overflow();
        clr(); set_bus();
        for (int i = 0; i < 5; i++) begin
            rd_bad(10 + i, 16'h100 + i);
            if (i < 4) fq.push_back(fw(10 + i, 16'h100 + i));
        end
        idle_n(3);
        checks++;
        if (FAIL_OVERFLOW !== 1'b1 || FAIL_COUNT !== 8'd5 || FAIL_ADDR !== fw(10, 16'h100)) begin
            errors++; $display("FAIL ovf_state got %b/%0d/%04h required 1/5/%04h", FAIL_OVERFLOW, FAIL_COUNT, FAIL_ADDR, fw(10, 16'h100));
        end
        drain(4);
        checks++;
        if (FAIL_VALID !== 1'b0 || fq.size() != 0 || FAIL_OVERFLOW !== 1'b1) begin
            errors++; $display("FAIL ovf_drain got %b/%0d/%b required 0/0/1", FAIL_VALID, fq.size(), FAIL_OVERFLOW);
        end
    endtask

    task automatic test_full_pop_push();
        clr(); set_bus();
        for (int i = 0; i < 4; i++) begin
            rd_bad(20 + i, 16'h200 + i);
            fq.push_back(fw(20 + i, 16'h200 + i));
        end
        idle_n(3);
        checks++;
        if (FAIL_COUNT !== 8'd4 || FAIL_OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL full_fill got %0d/%b required 4/0", FAIL_COUNT, FAIL_OVERFLOW);
        end
        rd_bad(30, 16'h2FF);
        fq.push_back(fw(30, 16'h2FF));
        idle_n(2);
        FAIL_READY = 1'b1;   // pop lands on the same edge as the push
        idle();
        FAIL_READY = 1'b0;
        checks++;
        if (FAIL_OVERFLOW !== 1'b0 || FAIL_COUNT !== 8'd5 || FAIL_ADDR !== fw(21, 16'h201) || fq.size() != 4) begin
            errors++; $display("FAIL full_pop got %b/%0d/%04h/%0d required 0/5/%04h/4", FAIL_OVERFLOW, FAIL_COUNT, FAIL_ADDR, fq.size(), fw(21, 16'h201));
        end
        drain(4);
        checks++;
        if (FAIL_VALID !== 1'b0 || fq.size() != 0) begin
            errors++; $display("FAIL full_drain got %b/%0d required 0/0", FAIL_VALID, fq.size());
        end
    endtask

    task automatic test_csb_clr();
        logic [63:0] two_low;
        clr(); set_bus();
        two_low = csb_of(7);
        two_low[9] = 1'b0;
        rd_bad(3, 16'h033);                                   // stays in the log
        rd(7, 16'h077, 1'b1, ~MEM_ODATA_BUS[8*7 +: 8], two_low);
        rd(8, 16'h088, 1'b1, ~MEM_ODATA_BUS[8*8 +: 8], '1);   // no CSB low
        idle_n(3);
        checks++;
        if (CSB_ERR !== 1'b1 || FAIL_COUNT !== 8'd1 || FAIL_VALID !== 1'b1 || FAIL_ADDR !== fw(3, 16'h033)) begin
            errors++; $display("FAIL csb_err got %b/%0d/%b/%04h required 1/1/1/%04h", CSB_ERR, FAIL_COUNT, FAIL_VALID, FAIL_ADDR, fw(3, 16'h033));
        end
        checks++;
        if (BIST_ODATA !== 8'(8 * 7 + 17)) begin
            errors++; $display("FAIL csb_data got %02h required %02h", BIST_ODATA, 8'(8 * 7 + 17));
        end
        clr();
        checks++;
        if (CSB_ERR !== 1'b0 || FAIL_COUNT !== 8'd0 || FAIL_VALID !== 1'b0 || FAIL_OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL clr got %b/%0d/%b/%b required 0/0/0/0", CSB_ERR, FAIL_COUNT, FAIL_VALID, FAIL_OVERFLOW);
        end
    endtask

    task automatic test_repeat_addr();
        int n_log;
        clr(); set_bus();
`ifdef MEM_RDATA_CHECKER_DEDUP_EN
        n_log = 1;
`else
        n_log = 3;
`endif
        for (int i = 0; i < 3; i++) rd_bad(40, 16'h2AA);
        for (int i = 0; i < n_log; i++) fq.push_back(fw(40, 16'h2AA));
        idle_n(4);
        checks++;
        if (FAIL_COUNT !== 8'd3 || FAIL_OVERFLOW !== 1'b0) begin
            errors++; $display("FAIL repeat_cnt got %0d/%b required 3/0", FAIL_COUNT, FAIL_OVERFLOW);
        end
        drain(3);
        checks++;
        if (FAIL_VALID !== 1'b0 || fq.size() != 0) begin
            errors++; $display("FAIL repeat_log got %b/%0d required 0/0", FAIL_VALID, fq.size());
        end
    endtask

    task automatic test_back_to_back();
        clr(); set_bus();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) begin
                rd_bad(i, 16'h010 * i);
                fq.push_back(fw(i, 16'h010 * i));
            end else
                rd(i, 16'h010 * i, 1'b1, MEM_ODATA_BUS[8*i +: 8], csb_of(i));
        end
        idle_n(4);
        checks++;
        if (FAIL_COUNT !== 8'd4 || FAIL_OVERFLOW !== 1'b0 || bq.size() != 0) begin
            errors++; $display("FAIL b2b_cnt got %0d/%b/%0d required 4/0/0", FAIL_COUNT, FAIL_OVERFLOW, bq.size());
        end
        drain(4);
        checks++;
        if (FAIL_VALID !== 1'b0 || fq.size() != 0) begin
            errors++; $display("FAIL b2b_drain got %b/%0d required 0/0", FAIL_VALID, fq.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        clr(); set_bus();
        for (int i = 0; i < 5; i++) rd_bad(50 + i, 16'h300 + i);
        #3;
        MEM_CE = 1'b0; MEM_WEB = 1'b0;
        RSTN = 1'b0;
        #1;
        bq.delete();
        fq.delete();
        checks++;
        if (BIST_ODATA !== 8'h0 || BIST_ODATA_VALID !== 1'b0 || FAIL_VALID !== 1'b0 || FAIL_ADDR !== 16'h0 ||
            FAIL_COUNT !== 8'h0 || FAIL_OVERFLOW !== 1'b0 || CSB_ERR !== 1'b0) begin
            errors++; $display("FAIL mid_rst got %02h/%b/%b/%04h/%0d/%b/%b required all zero", BIST_ODATA,
                BIST_ODATA_VALID, FAIL_VALID, FAIL_ADDR, FAIL_COUNT, FAIL_OVERFLOW, CSB_ERR);
        end
        @(posedge CLK); @(posedge CLK); #3;
        RSTN = 1'b1;
        idle_n(5);
        checks++;
        if (FAIL_VALID !== 1'b0 || FAIL_COUNT !== 8'h0 || BIST_ODATA !== 8'h0 || FAIL_ADDR !== 16'h0) begin
            errors++; $display("FAIL post_rst got %b/%0d/%02h/%04h required 0/0/00/0000", FAIL_VALID, FAIL_COUNT, BIST_ODATA, FAIL_ADDR);
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_overflow();
        test_full_pop_push();
        test_csb_clr();
        test_repeat_addr();
        test_back_to_back();
        test_reset_mid_burst();
        idle_n(2);
        checks++;
        if (bq.size() != 0 || fq.size() != 0) begin
            errors++; $display("FAIL scoreboard_left got %0d/%0d required 0/0", bq.size(), fq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
